hdr_ddr_target_rx: RTL

//  Target-side receiver for I3C HDR-DDR frames; the far end of the controller HDR engine's DDR path.

---
 rtl/hdr_ddr_target_rx_if.sv | 38 +++
 rtl/hdr_ddr_target_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_ddr_target_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : hdr_ddr_target_rx_if
// Description : Bit-stream inputs and decoded word outputs of the HDR-DDR
//               target receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface hdr_ddr_target_rx_if;
   logic        i_en;
   logic [6:0]  i_dyn_addr;
   logic        i_bit_vld;
   logic        i_bit;
   logic        i_restart;
   logic        i_exit;
   logic        o_cmd_vld;
   logic        o_rnw;
   logic [6:0]  o_cmd_code;
   logic        o_addr_match;
   logic        o_data_vld;
   logic [15:0] o_data;
   logic        o_frame_done;
   logic        o_err;
   logic [2:0]  o_err_code;
   logic        o_busy;

   modport master (
      output i_en, i_dyn_addr, i_bit_vld, i_bit, i_restart, i_exit,
      input  o_cmd_vld, o_rnw, o_cmd_code, o_addr_match, o_data_vld, o_data,
             o_frame_done, o_err, o_err_code, o_busy
   );

   modport slave (
      input  i_en, i_dyn_addr, i_bit_vld, i_bit, i_restart, i_exit,
      output o_cmd_vld, o_rnw, o_cmd_code, o_addr_match, o_data_vld, o_data,
             o_frame_done, o_err, o_err_code, o_busy
   );
endinterface
`default_nettype wire

// File: rtl/hdr_ddr_target_rx.sv
`default_nettype none
// ============================================================================
// Module      : hdr_ddr_target_rx
// Description : I3C HDR-DDR target receiver: deserializes command/data/CRC
//               words, checks preamble, parity and CRC5, delivers write data.
// Revision    : 1.0 - initial release
// ============================================================================
module hdr_ddr_target_rx #(
   parameter int         MAX_WORDS = 8,
   parameter logic [4:0] CRC_INIT  = 5'h1F
) (
   input  wire logic            i_sys_clk,
   input  wire logic            i_sys_rst,
   hdr_ddr_target_rx_if.slave   bus
);

   localparam int                c_WCNT_W    = $clog2(MAX_WORDS + 1);
   localparam logic [c_WCNT_W-1:0] c_MAX_WCNT = c_WCNT_W'(MAX_WORDS);
   localparam logic [4:0]        c_WORD_BITS = 5'd20;
   localparam logic [4:0]        c_CRC_BITS  = 5'd9;
   localparam logic [1:0]        c_PRE_CMD   = 2'b01;
   localparam logic [1:0]        c_PRE_DATA  = 2'b11;
   localparam logic [3:0]        c_CRC_TOKEN = 4'hC;
   localparam logic [2:0]        c_ERR_PAR   = 3'd1;
   localparam logic [2:0]        c_ERR_PRE   = 3'd2;
   localparam logic [2:0]        c_ERR_TOK   = 3'd3;
   localparam logic [2:0]        c_ERR_CRC   = 3'd4;
   localparam logic [2:0]        c_ERR_OVF   = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CMD  = 3'd1,
      S_DATA = 3'd2,
      S_CRC  = 3'd3,
      S_WAIT = 3'd4
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [4:0]          r_bit_cnt, w_bit_cnt_nxt, w_cnt_inc;
   logic [18:0]         r_shift, w_shift_nxt;
   logic [19:0]         w_shift_in;
   logic [4:0]          r_crc, w_crc_nxt;
   logic [c_WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
   logic [15:0]         w_payload;
   logic                w_par_ok, w_addr_hit;
   logic                r_cmd_vld, w_cmd_vld_nxt;
   logic                r_rnw, w_rnw_nxt;
   logic [6:0]          r_cmd_code, w_cmd_code_nxt;
   logic                r_addr_match, w_addr_match_nxt;
   logic                r_data_vld, w_data_vld_nxt;
   logic [15:0]         r_data, w_data_nxt;
   logic                r_done, w_done_nxt;
   logic                r_err, w_err_nxt;
   logic [2:0]          r_err_code, w_err_code_nxt;

   // Parity pair {PA1, PA0}: PA1 over odd bits, PA0 over even bits inverted.
   function automatic logic [1:0] ddr_parity(input logic [15:0] d);
      logic pa1, pa0;
      pa1 = 1'b0;
      pa0 = 1'b1;
      for (int k = 0; k < 8; k++) begin
         pa1 = pa1 ^ d[2*k+1];
         pa0 = pa0 ^ d[2*k];
      end
      return {pa1, pa0};
   endfunction

   function automatic logic [4:0] crc5_word(input logic [4:0] seed, input logic [15:0] d);
      logic [4:0] c;
      logic       fb;
      c = seed;
      for (int k = 15; k >= 0; k--) begin
         fb = c[4] ^ d[k];
         c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
      end
      return c;
   endfunction

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         r_state      <= S_IDLE;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_crc        <= CRC_INIT;
         r_wcnt       <= '0;
         r_cmd_vld    <= 1'b0;
         r_rnw        <= 1'b0;
         r_cmd_code   <= '0;
         r_addr_match <= 1'b0;
         r_data_vld   <= 1'b0;
         r_data       <= '0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_err_code   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_shift      <= w_shift_nxt;
         r_crc        <= w_crc_nxt;
         r_wcnt       <= w_wcnt_nxt;
         r_cmd_vld    <= w_cmd_vld_nxt;
         r_rnw        <= w_rnw_nxt;
         r_cmd_code   <= w_cmd_code_nxt;
         r_addr_match <= w_addr_match_nxt;
         r_data_vld   <= w_data_vld_nxt;
         r_data       <= w_data_nxt;
         r_done       <= w_done_nxt;
         r_err        <= w_err_nxt;
         r_err_code   <= w_err_code_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_shift_nxt      = r_shift;
      w_crc_nxt        = r_crc;
      w_wcnt_nxt       = r_wcnt;
      w_cmd_vld_nxt    = 1'b0;
      w_data_vld_nxt   = 1'b0;
      w_done_nxt       = 1'b0;
      w_err_nxt        = 1'b0;
      w_err_code_nxt   = r_err_code;
      w_rnw_nxt        = r_rnw;
      w_cmd_code_nxt   = r_cmd_code;
      w_addr_match_nxt = r_addr_match;
      w_data_nxt       = r_data;
      w_shift_in       = {r_shift, bus.i_bit};
      w_cnt_inc        = r_bit_cnt + 5'd1;
      w_payload        = w_shift_in[17:2];
      w_par_ok         = (w_shift_in[1:0] == ddr_parity(w_payload));
      w_addr_hit       = (w_payload[7:1] == bus.i_dyn_addr);

      if (r_state == S_IDLE) begin
         w_bit_cnt_nxt = '0;
         if (bus.i_en) w_state_nxt = S_CMD;
      end else if (!bus.i_en || bus.i_exit) begin
         w_state_nxt   = S_IDLE;
         w_bit_cnt_nxt = '0;
      end else if (bus.i_restart) begin
         // A word completing in this same cycle is discarded silently.
         w_state_nxt   = S_CMD;
         w_bit_cnt_nxt = '0;
      end else if (bus.i_bit_vld && (r_state != S_WAIT)) begin
         w_shift_nxt   = w_shift_in[18:0];
         w_bit_cnt_nxt = w_cnt_inc;
         case (r_state)
            S_CMD: begin
               if (w_cnt_inc == c_WORD_BITS) begin
                  w_bit_cnt_nxt = '0;
                  w_state_nxt   = S_WAIT;
                  if (w_shift_in[19:18] != c_PRE_CMD) begin
                     w_err_nxt      = 1'b1;
                     w_err_code_nxt = c_ERR_PRE;
                  end else if (!w_par_ok) begin
                     w_err_nxt      = 1'b1;
                     w_err_code_nxt = c_ERR_PAR;
                  end else begin
                     w_cmd_vld_nxt    = 1'b1;
                     w_rnw_nxt        = w_payload[15];
                     w_cmd_code_nxt   = w_payload[14:8];
                     w_addr_match_nxt = w_addr_hit;
                     w_crc_nxt        = CRC_INIT;
                     w_wcnt_nxt       = '0;
                     if (w_addr_hit && !w_payload[15]) w_state_nxt = S_DATA;
                  end
               end
            end
            S_DATA: begin
               // The first two bits decide between another data word and the CRC word.
               if (w_cnt_inc == 5'd2) begin
                  if (w_shift_in[1:0] == c_PRE_CMD) begin
                     w_state_nxt   = S_CRC;
                     w_bit_cnt_nxt = '0;
                  end else if (w_shift_in[1:0] != c_PRE_DATA) begin
                     w_state_nxt    = S_WAIT;
                     w_bit_cnt_nxt  = '0;
                     w_err_nxt      = 1'b1;
                     w_err_code_nxt = c_ERR_PRE;
                  end
               end else if (w_cnt_inc == c_WORD_BITS) begin
                  w_bit_cnt_nxt = '0;
                  if (!w_par_ok) begin
                     w_state_nxt    = S_WAIT;
                     w_err_nxt      = 1'b1;
                     w_err_code_nxt = c_ERR_PAR;
                  end else if (r_wcnt == c_MAX_WCNT) begin
                     w_state_nxt    = S_WAIT;
                     w_err_nxt      = 1'b1;
                     w_err_code_nxt = c_ERR_OVF;
                  end else begin
                     w_data_vld_nxt = 1'b1;
                     w_data_nxt     = w_payload;
                     w_crc_nxt      = crc5_word(r_crc, w_payload);
                     w_wcnt_nxt     = r_wcnt + c_WCNT_W'(1);
                  end
               end
            end
            S_CRC: begin
               if (w_cnt_inc == c_CRC_BITS) begin
                  w_bit_cnt_nxt = '0;
                  w_state_nxt   = S_WAIT;
                  if (w_shift_in[8:5] != c_CRC_TOKEN) begin
                     w_err_nxt      = 1'b1;
                     w_err_code_nxt = c_ERR_TOK;
                  end else if (w_shift_in[4:0] == r_crc) begin
                     w_done_nxt     = 1'b1;
                  end else begin
                     w_err_nxt      = 1'b1;
                     w_err_code_nxt = c_ERR_CRC;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_cmd_vld    = r_cmd_vld;
   assign bus.o_rnw        = r_rnw;
   assign bus.o_cmd_code   = r_cmd_code;
   assign bus.o_addr_match = r_addr_match;
   assign bus.o_data_vld   = r_data_vld;
   assign bus.o_data       = r_data;
   assign bus.o_frame_done = r_done;
   assign bus.o_err        = r_err;
   assign bus.o_err_code   = r_err_code;
   assign bus.o_busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
